led_pattern_sequencer: RTL and testbench

- Controller that sequences the board's five LED outputs through selectable blink patterns at a programmable step rate.
- A push-button, debounced in-block, cycles the active pattern. A pause input freezes stepping.
- Sits between the top-level button/LED pins and replaces free-running per-LED toggle counters with one shared step timebase and a mode FSM.

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_pattern_sequencer_debouncer.sv | 75 +++++++
 rtl/led_pattern_sequencer.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared mode/direction encodings and LED constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {
        MODE_OFF       = 3'd0,
        MODE_CHASE     = 3'd1,
        MODE_BOUNCE    = 3'd2,
        MODE_BINARY    = 3'd3,
        MODE_ALL_BLINK = 3'd4
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [4:0] LED_ALL_ON = 5'b11111;

endpackage

// File: rtl/led_pattern_sequencer_debouncer.sv
// Button synchroniser, debouncer and single-cycle press detector.
module button_debouncer #(
    parameter int N_CLKS_DEBOUNCE = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(N_CLKS_DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic [1:0]    settle;
    logic          armed;
    logic          accept;
    logic          press;

    assign accept  = (sync2 != level) && (cnt == CW'(N_CLKS_DEBOUNCE - 1));
    assign o_press = press;

    // Two-flop synchroniser on the raw button
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it has been stable long enough
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync2 != level) begin
            if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Arm press detection only once the synchronised button has been seen
    // low after reset (sync2 is trusted from the third edge on), so a button
    // held through reset release does not count as a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & ~sync2);
        end
    end

    // One-cycle pulse on an accepted 0->1 debounced transition
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            press <= 1'b0;
        end else begin
            press <= armed & accept & sync2;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: shared step timebase, mode FSM and LED pattern output.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_CLKS_STEP     = 12500000,
    parameter int N_CLKS_DEBOUNCE = 500000,
    parameter int N_LEDS          = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_btn,
    input  logic              i_pause,
    output logic [N_LEDS-1:0] o_led,
    output logic [2:0]        o_mode,
    output logic              o_tick
);

    localparam int TW = $clog2(N_CLKS_STEP);

    logic              press;
    mode_t             mode;
    mode_t             mode_next;
    dir_t              dir;
    dir_t              dir_next;
    logic [4:0]        step;
    logic [4:0]        step_next;
    logic [TW-1:0]     tick_cnt;
    logic              raw_tick;
    logic              step_tick;
    logic [N_LEDS-1:0] led;
    logic [N_LEDS-1:0] led_next;
    logic              tick;

    button_debouncer #(
        .N_CLKS_DEBOUNCE(N_CLKS_DEBOUNCE)
    ) u_debouncer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn),
        .o_press (press)
    );

    // A press in the same cycle as an accepted tick wins; the tick is dropped
    assign raw_tick  = (tick_cnt == TW'(N_CLKS_STEP - 1));
    assign step_tick = raw_tick & ~i_pause & (mode != MODE_OFF) & ~press;

    assign o_led  = led;
    assign o_mode = mode;
    assign o_tick = tick;

    // Free-running step timebase, restarted by a press; runs through pause
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
        end else if (press || raw_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Mode, step and direction state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode <= MODE_OFF;
            step <= '0;
            dir  <= DIR_UP;
        end else begin
            mode <= mode_next;
            step <= step_next;
            dir  <= dir_next;
        end
    end

    // Mode advance on press, otherwise per-mode step update on accepted ticks
    always_comb begin
        mode_next = mode;
        step_next = step;
        dir_next  = dir;
        if (press) begin
            step_next = '0;
            dir_next  = DIR_UP;
            case (mode)
                MODE_OFF:       mode_next = MODE_CHASE;
                MODE_CHASE:     mode_next = MODE_BOUNCE;
                MODE_BOUNCE:    mode_next = MODE_BINARY;
                MODE_BINARY:    mode_next = MODE_ALL_BLINK;
                default:        mode_next = MODE_OFF;
            endcase
        end else begin
            case (mode)
                MODE_OFF: begin
                end
                MODE_CHASE: begin
                    if (step_tick) begin
                        step_next = (step == 5'd4) ? 5'd0 : step + 5'd1;
                    end
                end
                MODE_BOUNCE: begin
                    if (step_tick) begin
                        if (dir == DIR_UP) begin
                            if (step == 5'd3) begin
                                step_next = 5'd4;
                                dir_next  = DIR_DOWN;
                            end else begin
                                step_next = step + 5'd1;
                            end
                        end else begin
                            if (step == 5'd1) begin
                                step_next = 5'd0;
                                dir_next  = DIR_UP;
                            end else begin
                                step_next = step - 5'd1;
                            end
                        end
                    end
                end
                MODE_BINARY: begin
                    if (step_tick) begin
                        step_next = step + 5'd1;
                    end
                end
                MODE_ALL_BLINK: begin
                    if (step_tick) begin
                        step_next = {step[4:1], ~step[0]};
                    end
                end
                default: begin
                    mode_next = MODE_OFF;
                    step_next = '0;
                    dir_next  = DIR_UP;
                end
            endcase
        end
    end

    // LED pattern decode from the current mode and step
    always_comb begin
        led_next = '0;
        case (mode)
            MODE_CHASE,
            MODE_BOUNCE:    led_next = 5'b00001 << step;
            MODE_BINARY:    led_next = step;
            MODE_ALL_BLINK: led_next = step[0] ? 5'b00000 : LED_ALL_ON;
            default:        led_next = '0;
        endcase
    end

    // Registered LED and tick outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            led  <= '0;
            tick <= 1'b0;
        end else begin
            led  <= led_next;
            tick <= step_tick;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with a queue of expected LED steps.
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       pause;
    logic [4:0] led;
    logic [2:0] mode;
    logic       tick;

    int unsigned total;
    int unsigned bad;
    logic        mon_en;
    logic        tick_prev;
    logic [4:0]  exp_q[$];

    led_pattern_sequencer #(
        .N_CLKS_STEP     (4),
        .N_CLKS_DEBOUNCE (3),
        .N_LEDS          (5)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn),
        .i_pause (pause),
        .o_led   (led),
        .o_mode  (mode),
        .o_tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; every tick shown on the previous
    // sample must be followed by the next expected LED value from the queue.
    task automatic cycle();
        @(negedge clk);
        if (mon_en) begin
            if (tick_prev) begin
                check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("led_step", 32'(led), 32'(exp_q.pop_front()));
                end
            end
            tick_prev = tick;
        end else begin
            tick_prev = 1'b0;
        end
    endtask

    task automatic push(input logic [4:0] v);
        exp_q.push_back(v);
    endtask

    task automatic wait_drain(input int unsigned bound);
        for (int unsigned i = 0; i < bound && exp_q.size() != 0; i++) begin
            cycle();
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Button already high for k0 samples: wait for the mode change, then
    // check latency, the dropped tick and the first displayed pattern.
    task automatic wait_mode(input logic [2:0] m, input int unsigned k0, input logic [4:0] first_led);
        int unsigned k;
        k = k0;
        while (mode != m && k < 10) begin
            cycle();
            k++;
        end
        check("mode", 32'(mode), 32'(m));
        check("press_lat", 32'(k <= 6), 32'd1);
        check("tick_at_press", 32'(tick), 32'd0);
        mon_en = 1'b1;
        cycle();
        check("first_led", 32'(led), 32'(first_led));
        btn = 1'b0;
    endtask

    task automatic press_to(input logic [2:0] m, input logic [4:0] first_led);
        mon_en = 1'b0;
        btn = 1'b1;
        wait_mode(m, 0, first_led);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n_tick;
        int unsigned n_led;
        int unsigned n_mode;
        logic [4:0]  held;

        total     = 0;
        bad       = 0;
        mon_en    = 1'b0;
        tick_prev = 1'b0;
        rst_n     = 1'b0;
        btn       = 1'b0;
        pause     = 1'b0;

        repeat (3) cycle();
        check("rst_led", 32'(led), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;

        n_tick = 0;
        n_led  = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick) n_tick++;
            if (led != 5'd0) n_led++;
        end
        check("idle_tick", n_tick, 32'd0);
        check("idle_led", n_led, 32'd0);
        check("idle_mode", 32'(mode), 32'd0);

        btn = 1'b1;
        repeat (2) cycle();
        btn = 1'b0;
        repeat (10) cycle();
        check("glitch_mode", 32'(mode), 32'd0);

        press_to(MODE_CHASE, 5'b00001);
        push(5'b00010); push(5'b00100); push(5'b01000); push(5'b10000); push(5'b00001);
        wait_drain(40);

        press_to(MODE_BOUNCE, 5'b00001);
        push(5'b00010); push(5'b00100); push(5'b01000); push(5'b10000); push(5'b01000);
        push(5'b00100); push(5'b00010); push(5'b00001); push(5'b00010);
        wait_drain(60);

        press_to(MODE_BINARY, 5'b00000);
        for (int v = 1; v < 32; v++) push(5'(v));
        push(5'b00000);
        wait_drain(160);

        press_to(MODE_ALL_BLINK, 5'b11111);
        push(5'b00000); push(5'b11111); push(5'b00000);
        wait_drain(20);
        pause  = 1'b1;
        held   = led;
        n_tick = 0;
        n_led  = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tick) n_tick++;
            if (led != held) n_led++;
        end
        check("pause_tick", n_tick, 32'd0);
        check("pause_led", n_led, 32'd0);
        pause = 1'b0;
        push(5'b11111); push(5'b00000);
        wait_drain(10);

        press_to(MODE_OFF, 5'b00000);
        repeat (10) cycle();

        press_to(MODE_CHASE, 5'b00001);
        push(5'b00010); push(5'b00100);
        wait_drain(20);
        mon_en = 1'b0;
        cycle();
        btn = 1'b1;
        repeat (4) cycle();
        check("step3_led", 32'(led), 32'(5'b01000));
        wait_mode(MODE_BOUNCE, 4, 5'b00001);
        push(5'b00010); push(5'b00100);
        wait_drain(20);

        press_to(MODE_BINARY, 5'b00000);
        push(5'b00001); push(5'b00010);
        wait_drain(20);

        mon_en = 1'b0;
        btn = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        n_mode = 0;
        n_led  = 0;
        n_tick = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (mode != 3'd0) n_mode++;
            if (led != 5'd0) n_led++;
            if (tick) n_tick++;
        end
        check("held_mode", n_mode, 32'd0);
        check("held_led", n_led, 32'd0);
        check("held_tick", n_tick, 32'd0);
        btn = 1'b0;
        repeat (8) cycle();
        press_to(MODE_CHASE, 5'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
